// File: rtl/spider_wave_scheduler_if.sv
// Signal bundle between the game FSM / spider enemy controller and the wave scheduler.
// The master side is the scheduler itself; the slave side is its environment.
interface spider_wave_scheduler_if;
  logic       game_start;
  logic       player_dead;
  logic       spider_alive;
  logic       spider_enable;
  logic [3:0] wave_num;
  logic       wave_cleared;
  logic       all_clear;
  logic       game_over;
  logic [2:0] state_out;

  modport master (
    input  game_start, player_dead, spider_alive,
    output spider_enable, wave_num, wave_cleared, all_clear, game_over, state_out
  );

  modport slave (
    output game_start, player_dead, spider_alive,
    input  spider_enable, wave_num, wave_cleared, all_clear, game_over, state_out
  );
endinterface

// File: rtl/spider_wave_scheduler.sv
// Runs the spider boss through NUM_WAVES waves: spawn delay, active fight, cooldown,
// then all-clear; player death from any in-play state ends the game.
module spider_wave_scheduler #(
  parameter int unsigned SPAWN_DELAY     = 25_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
  parameter int unsigned NUM_WAVES       = 3
) (
  input  logic                           clk25,
  input  logic                           reset,
  spider_wave_scheduler_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN_WAIT = 3'd1,
    ACTIVE     = 3'd2,
    COOLDOWN   = 3'd3,
    CLEARED    = 3'd4,
    GAME_OVER  = 3'd5
  } state_e;

  localparam logic [25:0] SPAWN_LAST = 26'(SPAWN_DELAY - 1);
  localparam logic [25:0] COOL_LAST  = 26'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]  LAST_WAVE  = 4'(NUM_WAVES);

  state_e      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [3:0]  wave_q, wave_d;
  logic        armed_q, armed_d;
  logic        wave_cleared_q, wave_cleared_d;
  logic        all_clear_q, all_clear_d;
  logic        game_over_q, game_over_d;
  logic        kill;

  // A kill is only meaningful once the spider has been seen alive in this wave.
  assign kill = armed_q && !bus.spider_alive;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    wave_d         = wave_q;
    armed_d        = armed_q;
    wave_cleared_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.game_start) begin
          state_d = SPAWN_WAIT;
          wave_d  = 4'd1;
        end
      end
      SPAWN_WAIT: begin
        if (bus.player_dead) begin
          state_d = GAME_OVER;
        end else if (timer_q == SPAWN_LAST) begin
          state_d = ACTIVE;
          armed_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (bus.player_dead) begin
          state_d = GAME_OVER;
        end else if (kill) begin
          wave_cleared_d = 1'b1;
          state_d        = (wave_q == LAST_WAVE) ? CLEARED : COOLDOWN;
        end else if (bus.spider_alive) begin
          armed_d = 1'b1;
        end
      end
      COOLDOWN: begin
        if (bus.player_dead) begin
          state_d = GAME_OVER;
        end else if (timer_q == COOL_LAST) begin
          state_d = SPAWN_WAIT;
          wave_d  = wave_q + 4'd1;
        end
      end
      CLEARED, GAME_OVER: begin
        if (bus.game_start) begin
          state_d = SPAWN_WAIT;
          wave_d  = 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every transition changes state, so a state change is exactly a state entry.
    timer_d     = (state_d != state_q) ? 26'd0 : timer_q + 26'd1;
    all_clear_d = (state_d == CLEARED);
    game_over_d = (state_d == GAME_OVER);
  end

  always_ff @(posedge clk25) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= 26'd0;
      wave_q         <= 4'd0;
      armed_q        <= 1'b0;
      wave_cleared_q <= 1'b0;
      all_clear_q    <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      wave_q         <= wave_d;
      armed_q        <= armed_d;
      wave_cleared_q <= wave_cleared_d;
      all_clear_q    <= all_clear_d;
      game_over_q    <= game_over_d;
    end
  end

  // Gating with spider_alive drops enable in the very cycle the spider dies, so the
  // enemy controller never respawns a killed spider within the wave.
  assign bus.spider_enable = (state_q == ACTIVE) && (!armed_q || bus.spider_alive);
  assign bus.wave_num      = wave_q;
  assign bus.wave_cleared  = wave_cleared_q;
  assign bus.all_clear     = all_clear_q;
  assign bus.game_over     = game_over_q;
  assign bus.state_out     = state_q;

endmodule
